uart_tx: RTL and testbench

- Transmit half of the UART loopback path. Accepts bytes into an internal FIFO and serialises each one on txd.
- Frame format: 1 start bit, 8 data bits LSB first, optional even or odd parity, then 1 or 2 stop bits.
- Uses the same runtime configuration inputs as the receive side (baud_max_cnt, parity_sel, stop_sel), so txd connects directly to the receiver's rxd.

---
 rtl/uart_tx.sv | 132 +++++++++++++
 tb/tb_uart_tx.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO feeding a start/data/parity/stop serialiser.
// Frame format and bit timing are set at run time and match the receive side.
module uart_tx #(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic        mclk,
  input  logic        n_reset,
  input  logic [15:0] baud_max_cnt,
  input  logic [1:0]  parity_sel,
  input  logic        stop_sel,
  input  logic [7:0]  wr_data,
  input  logic        wr_en,
  output logic        full,
  output logic        empty,
  output logic        wr_overflow,
  output logic        busy,
  output logic        tx_done,
  output logic        txd
);

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  localparam logic [FIFO_AW:0] DEPTH_CNT = (FIFO_AW+1)'(FIFO_DEPTH);

  state_t             state;
  logic [7:0]         mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count, count_next;
  logic               push, pop;

  logic [7:0]  sh;
  logic        par, cfg_par_en, cfg_stop;
  logic [15:0] cnt1;
  logic [3:0]  cnt2, last_pos, next_pos;
  logic        next_bit;

  assign push = wr_en & ~full;
  assign pop  = (state == IDLE) & ~empty;
  assign busy = (state != IDLE);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + (FIFO_AW+1)'(1);
    else if (pop && !push) count_next = count - (FIFO_AW+1)'(1);
  end

  // NOTE: the storage array is deliberately not reset; count and pointers define validity.
  always_ff @(posedge mclk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge mclk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      wr_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      count       <= count_next;
      full        <= (count_next == DEPTH_CNT);
      empty       <= (count_next == '0);
      wr_overflow <= wr_en & full;
    end
  end

  // Position 9 is parity only when the frame carries one; everything past the data is stop.
  assign last_pos = 4'd9 + {3'b000, cfg_par_en} + {3'b000, cfg_stop};
  assign next_pos = cnt2 + 4'd1;

  always_comb begin
    next_bit = 1'b1;
    if (next_pos >= 4'd1 && next_pos <= 4'd8) next_bit = sh[3'(next_pos - 4'd1)];
    else if (next_pos == 4'd9 && cfg_par_en)  next_bit = par;
  end

  always_ff @(posedge mclk or negedge n_reset) begin
    if (!n_reset) begin
      state      <= IDLE;
      sh         <= '0;
      par        <= 1'b0;
      cfg_par_en <= 1'b0;
      cfg_stop   <= 1'b0;
      cnt1       <= '0;
      cnt2       <= '0;
      txd        <= 1'b1;
      tx_done    <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (!empty) begin
            sh    <= mem[rd_ptr];
            state <= LOAD;
          end
        end
        LOAD: begin
          par        <= (parity_sel == 2'd2) ? ~^sh : ^sh;
          cfg_par_en <= (parity_sel == 2'd1) || (parity_sel == 2'd2);
          cfg_stop   <= stop_sel;
          cnt1       <= '0;
          cnt2       <= '0;
          txd        <= 1'b0;
          state      <= SEND;
        end
        SEND: begin
          if (cnt1 == baud_max_cnt) begin
            cnt1 <= '0;
            if (cnt2 == last_pos) begin
              txd     <= 1'b1;
              tx_done <= 1'b1;
              state   <= IDLE;
            end else begin
              cnt2 <= next_pos;
              txd  <= next_bit;
            end
          end else begin
            cnt1 <= cnt1 + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: per-vector bit-accurate frame checks plus
// FIFO overflow, mid-frame reset and a decoding receiver model.
module tb_uart_tx;

  logic        mclk = 1'b0;
  logic        n_reset;
  logic [15:0] baud_max_cnt;
  logic [1:0]  parity_sel;
  logic        stop_sel;
  logic [7:0]  wr_data;
  logic        wr_en;
  logic        full, empty, wr_overflow, busy, tx_done, txd;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  uart_tx #(.FIFO_DEPTH(16), .FIFO_AW(4)) dut (
    .mclk(mclk), .n_reset(n_reset), .baud_max_cnt(baud_max_cnt),
    .parity_sel(parity_sel), .stop_sel(stop_sel), .wr_data(wr_data),
    .wr_en(wr_en), .full(full), .empty(empty), .wr_overflow(wr_overflow),
    .busy(busy), .tx_done(tx_done), .txd(txd)
  );

  always #5 mclk = ~mclk;
  always @(posedge mclk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] baud;
    logic [1:0]  par;
    logic        stop;
    logic [7:0]  data;
    logic [11:0] frame;   // bit i = i-th bit on the line
    int          nbits;
    logic        flip;    // change config mid-frame
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic write_byte(input logic [7:0] d);
    @(negedge mclk);
    wr_data = d;
    wr_en   = 1'b1;
    @(posedge mclk);
    #1 wr_en = 1'b0;
  endtask

  task automatic run_vector(input vec_t v, input int idx);
    int good, busy_cnt, early, n;
    baud_max_cnt = v.baud;
    parity_sel   = v.par;
    stop_sel     = v.stop;
    write_byte(v.data);                     // E0
    check($sformatf("v%0d_not_empty", idx), empty, 0);
    @(posedge mclk); #1;                    // E1
    check($sformatf("v%0d_e1_busy", idx), busy, 1);
    check($sformatf("v%0d_e1_txd", idx), txd, 1);
    busy_cnt = 1;
    early = 0;
    @(posedge mclk); #1;                    // E2
    if (v.flip) begin
      parity_sel = (v.par == 2'd2) ? 2'd1 : 2'd2;
      stop_sel   = ~v.stop;
    end
    n = int'(v.baud) + 1;
    for (int b = 0; b < v.nbits; b++) begin
      good = 0;
      for (int c = 0; c < n; c++) begin
        if (txd === v.frame[b]) good++;
        if (busy) busy_cnt++;
        if (tx_done) early++;
        @(posedge mclk); #1;
      end
      check($sformatf("v%0d_bit%0d", idx, b), good, n);
    end
    check($sformatf("v%0d_done", idx), tx_done, 1);
    check($sformatf("v%0d_idle_busy", idx), busy, 0);
    check($sformatf("v%0d_idle_txd", idx), txd, 1);
    check($sformatf("v%0d_busy_cycles", idx), busy_cnt, v.nbits * n + 1);
    check($sformatf("v%0d_early_done", idx), early, 0);
    @(posedge mclk); #1;
    check($sformatf("v%0d_done_pulse", idx), tx_done, 0);
  endtask

  // Receiver model: samples mid-bit on falling clock edges.
  task automatic capture(input int pmode, input int nstop, output logic [7:0] data,
                         output logic par_ok, output logic stop_ok,
                         output int start_cyc, output logic timeout);
    int n, waited, lim;
    logic pbit;
    n = int'(baud_max_cnt) + 1;
    lim = 14 * n + 200;
    data = '0; par_ok = 1'b0; stop_ok = 1'b0; start_cyc = 0; timeout = 1'b0;
    waited = 0;
    @(negedge mclk);
    while (txd !== 1'b0) begin
      if (waited > lim) begin
        timeout = 1'b1;
        return;
      end
      @(negedge mclk);
      waited++;
    end
    start_cyc = cyc;
    repeat (n / 2) @(negedge mclk);
    for (int k = 0; k < 8; k++) begin
      repeat (n) @(negedge mclk);
      data[k] = txd;
    end
    par_ok = 1'b1;
    if (pmode == 1 || pmode == 2) begin
      repeat (n) @(negedge mclk);
      pbit = txd;
      par_ok = (pmode == 1) ? ((^data) == pbit) : ((~^data) == pbit);
    end
    stop_ok = 1'b1;
    for (int s = 0; s < nstop; s++) begin
      repeat (n) @(negedge mclk);
      stop_ok = stop_ok & txd;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic       pok, sok, to;
    int         sc, prev_sc, ov_cnt, low_cnt, busy_seen, done_seen, waited;

    vecs[0] = '{16'd9, 2'd0, 1'b0, 8'h55, 12'h2AA, 10, 1'b0};
    vecs[1] = '{16'd3, 2'd1, 1'b1, 8'h07, 12'hE0E, 12, 1'b0};
    vecs[2] = '{16'd3, 2'd2, 1'b1, 8'h07, 12'hC0E, 12, 1'b0};
    vecs[3] = '{16'd0, 2'd0, 1'b0, 8'h80, 12'h300, 10, 1'b0};
    vecs[4] = '{16'd2, 2'd2, 1'b0, 8'hA5, 12'h74A, 11, 1'b1};
    vecs[5] = '{16'd1, 2'd3, 1'b1, 8'h3C, 12'h678, 11, 1'b0};

    n_reset = 1'b0; wr_en = 1'b0; wr_data = '0;
    baud_max_cnt = 16'd9; parity_sel = '0; stop_sel = 1'b0;
    repeat (3) @(posedge mclk);
    #1;
    check("rst_txd", txd, 1);
    check("rst_busy", busy, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_done", tx_done, 0);
    check("rst_ovf", wr_overflow, 0);
    @(negedge mclk) n_reset = 1'b1;
    repeat (2) @(posedge mclk);

    for (int i = 0; i < 6; i++) run_vector(vecs[i], i);

    // Overflow: one long frame holds the shifter while 17 bytes arrive.
    baud_max_cnt = 16'd3; parity_sel = 2'd0; stop_sel = 1'b0;
    ov_cnt = 0;
    fork
      begin
        write_byte(8'hFF);
        repeat (2) @(posedge mclk);
        for (int i = 0; i < 17; i++) begin
          @(negedge mclk);
          wr_data = 8'(i);
          wr_en   = 1'b1;
          @(posedge mclk); #1;
          if (wr_overflow) ov_cnt++;
          if (i == 14) check("ovf_full_at_15", full, 0);
          if (i == 15) check("ovf_full_at_16", full, 1);
          if (i == 16) check("ovf_pulse", wr_overflow, 1);
        end
        wr_en = 1'b0;
        @(posedge mclk); #1;
        if (wr_overflow) ov_cnt++;
        check("ovf_pulse_end", wr_overflow, 0);
        check("ovf_count", ov_cnt, 1);
      end
      begin
        prev_sc = 0;
        for (int f = 0; f < 17; f++) begin
          capture(0, 1, d, pok, sok, sc, to);
          check($sformatf("ovf_timeout%0d", f), to, 0);
          check($sformatf("ovf_data%0d", f), d, (f == 0) ? 8'hFF : 8'(f - 1));
          check($sformatf("ovf_stop%0d", f), sok, 1);
          if (f > 0) check($sformatf("ovf_period%0d", f), sc - prev_sc, 42);
          prev_sc = sc;
        end
      end
    join
    waited = 0;
    while (busy && waited < 100) begin
      @(posedge mclk); #1;
      waited++;
    end
    check("ovf_drained_busy", busy, 0);
    check("ovf_drained_empty", empty, 1);
    low_cnt = 0;
    repeat (100) begin
      @(posedge mclk); #1;
      if (!txd) low_cnt++;
    end
    check("ovf_no_extra_frame", low_cnt, 0);

    // Reset in the middle of data bit 4 with 3 bytes still queued.
    for (int i = 0; i < 4; i++) write_byte(8'h0F);
    repeat (20) @(posedge mclk);
    @(negedge mclk);
    check("rst_mid_txd_before", txd, 0);
    n_reset = 1'b0;
    #1;
    check("rst_mid_txd", txd, 1);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_empty", empty, 1);
    check("rst_mid_full", full, 0);
    @(negedge mclk) n_reset = 1'b1;
    low_cnt = 0; busy_seen = 0; done_seen = 0;
    repeat (300) begin
      @(posedge mclk); #1;
      if (!txd) low_cnt++;
      if (busy) busy_seen++;
      if (tx_done) done_seen++;
    end
    check("rst_mid_no_txd", low_cnt, 0);
    check("rst_mid_no_busy", busy_seen, 0);
    check("rst_mid_no_done", done_seen, 0);

    // Loopback-style decode at the real baud setting with odd parity, 2 stops.
    baud_max_cnt = 16'd433; parity_sel = 2'd2; stop_sel = 1'b1;
    write_byte(8'h00);
    write_byte(8'hFF);
    write_byte(8'hA5);
    write_byte(8'h3C);
    for (int f = 0; f < 4; f++) begin
      logic [7:0] exp_b;
      case (f)
        0: exp_b = 8'h00;
        1: exp_b = 8'hFF;
        2: exp_b = 8'hA5;
        default: exp_b = 8'h3C;
      endcase
      capture(2, 2, d, pok, sok, sc, to);
      check($sformatf("lb_timeout%0d", f), to, 0);
      check($sformatf("lb_data%0d", f), d, exp_b);
      check($sformatf("lb_parity%0d", f), pok, 1);
      check($sformatf("lb_stop%0d", f), sok, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
